// File: rtl/uart_rx.sv
// uart_rx: receives frames from a byte-level UART deserializer and checks their CRC.
// Wire format: 0xFE, opt, len, data[0..len-1], crc[31:24], crc[23:16], crc[15:8], crc[7:0].
// The CRC is CRC-32/MPEG-2, computed over opt, len and data.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   in_byte, in_valid    byte stream, one-cycle strobe, no backpressure
//   full_data            {opt, len, data}; data byte 0 just below len; unused bytes 0
//   out_valid, out_ready output frame handshake
//   err_valid, err_code  one-cycle error pulse; code 1=crc 2=len 3=timeout 4=overrun (held)
module uart_rx #(
  parameter int unsigned FULL_DATA_SIZE = 40,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [BYTE_SIZE-1:0]      in_byte,
  input  logic                      in_valid,
  output logic [FULL_DATA_SIZE-1:0] full_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_valid,
  output logic [2:0]                err_code
);

  localparam int unsigned MAX_LEN  = (FULL_DATA_SIZE - 2*BYTE_SIZE) / BYTE_SIZE;
  localparam int unsigned IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [BYTE_SIZE-1:0] START_BYTE = BYTE_SIZE'(8'hFE);
  localparam logic [2:0] ERR_CRC     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_OPT, ST_LEN, ST_DATA, ST_CRC} state_t;

  state_t                    state_q, state_d;
  logic [FULL_DATA_SIZE-1:0] asm_q;
  logic [BYTE_SIZE-1:0]      len_q;
  logic [IDX_W-1:0]          idx_q;
  logic [1:0]                crc_cnt_q;
  logic [31:0]               crc_q;
  logic [31:0]               rx_crc_q;
  logic [TCNT_W-1:0]         tcnt_q;
  logic                      chk_pend_q;

  logic crc_init, crc_upd, clr_asm, opt_ld, len_ld, data_ld, rx_shift, chk_start;
  logic len_err, timeout;

  // One byte of MSB-first CRC-32/MPEG-2, unrolled over the byte's bits.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [BYTE_SIZE-1:0] b);
    logic [31:0] r;
    r = c;
    for (int i = BYTE_SIZE - 1; i >= 0; i--) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    crc_init  = 1'b0;
    crc_upd   = 1'b0;
    clr_asm   = 1'b0;
    opt_ld    = 1'b0;
    len_ld    = 1'b0;
    data_ld   = 1'b0;
    rx_shift  = 1'b0;
    chk_start = 1'b0;
    len_err   = 1'b0;
    timeout   = (state_q != ST_IDLE) && !in_valid && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (in_byte == START_BYTE) begin
            state_d  = ST_OPT;
            crc_init = 1'b1;
            clr_asm  = 1'b1;
          end
        end
        ST_OPT: begin
          opt_ld  = 1'b1;
          crc_upd = 1'b1;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          len_ld  = 1'b1;
          crc_upd = 1'b1;
          if (in_byte > BYTE_SIZE'(MAX_LEN)) begin
            len_err = 1'b1;
            state_d = ST_IDLE;
          end else if (in_byte == '0) begin
            state_d = ST_CRC;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          data_ld = 1'b1;
          crc_upd = 1'b1;
          if (BYTE_SIZE'(idx_q) == len_q - BYTE_SIZE'(1)) state_d = ST_CRC;
        end
        ST_CRC: begin
          rx_shift = 1'b1;
          if (crc_cnt_q == 2'd3) begin
            chk_start = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame assembly, CRC and inter-byte timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      asm_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      crc_cnt_q  <= '0;
      crc_q      <= '0;
      rx_crc_q   <= '0;
      tcnt_q     <= '0;
      chk_pend_q <= 1'b0;
    end else begin
      chk_pend_q <= chk_start;
      if (in_valid || state_q == ST_IDLE) tcnt_q <= '0;
      else                                tcnt_q <= tcnt_q + TCNT_W'(1);
      if (crc_init)     crc_q <= CRC_INIT;
      else if (crc_upd) crc_q <= crc_step(crc_q, in_byte);
      if (clr_asm) begin
        asm_q     <= '0;
        crc_cnt_q <= '0;
      end
      if (opt_ld) asm_q[FULL_DATA_SIZE-1 -: BYTE_SIZE] <= in_byte;
      if (len_ld) begin
        asm_q[FULL_DATA_SIZE-BYTE_SIZE-1 -: BYTE_SIZE] <= in_byte;
        len_q <= in_byte;
        idx_q <= '0;
      end
      if (data_ld) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          if (idx_q == IDX_W'(i))
            asm_q[FULL_DATA_SIZE-2*BYTE_SIZE-1-BYTE_SIZE*i -: BYTE_SIZE] <= in_byte;
        end
        idx_q <= idx_q + IDX_W'(1);
      end
      if (rx_shift) begin
        rx_crc_q  <= {rx_crc_q[31-BYTE_SIZE:0], in_byte};
        crc_cnt_q <= crc_cnt_q + 2'd1;
      end
    end
  end

  // Output register, handshake and error reporting; completion runs the cycle after the last CRC byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full_data <= '0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (len_err) begin
        err_valid <= 1'b1;
        err_code  <= ERR_LEN;
      end else if (timeout) begin
        err_valid <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (chk_pend_q) begin
        if (rx_crc_q != crc_q) begin
          err_valid <= 1'b1;
          err_code  <= ERR_CRC;
        end else if (out_valid && !out_ready) begin
          err_valid <= 1'b1;
          err_code  <= ERR_OVERRUN;
        end else begin
          full_data <= asm_q;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// scored against a table-driven CRC model and queues of expected outputs.
module tb_uart_rx;
  localparam int unsigned FDS = 40;
  localparam int unsigned TMO = 50;

  logic           CLK = 1'b0;
  logic           RST;
  logic [7:0]     in_byte;
  logic           in_valid;
  logic [FDS-1:0] full_data;
  logic           out_valid;
  logic           out_ready;
  logic           err_valid;
  logic [2:0]     err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int gap_max = 0;

  logic [FDS-1:0] data_q[$];
  logic [2:0]     err_q[$];
  logic [31:0]    crc_tbl[256];

  uart_rx #(.FULL_DATA_SIZE(FDS), .BYTE_SIZE(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .in_byte(in_byte), .in_valid(in_valid),
    .full_data(full_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte-wise table CRC-32/MPEG-2 reference.
  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic [7:0]  ix;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      ix = c[31:24] ^ b[i];
      c  = {c[23:0], 8'h00} ^ crc_tbl[ix];
    end
    return c;
  endfunction

  // Inputs are driven 1 time unit after a rising edge; each call ends at the same phase.
  task automatic drive(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drive_gap(input logic [7:0] b);
    drive(b);
    idle($urandom_range(0, gap_max));
  endtask

  // Sends a frame and records the response the receiver owes for it.
  task automatic send_frame(input logic [7:0] opt, input logic [7:0] len, input logic [23:0] data,
                            input logic [7:0] crc_xor, input bit ovr);
    logic [7:0]     q[$];
    logic [31:0]    crc;
    logic [FDS-1:0] fd;
    q = {opt, len};
    for (int i = 0; i < int'(len); i++) q.push_back(data[23-8*i -: 8]);
    crc = model_crc(q);
    fd  = '0;
    fd[39:32] = opt;
    fd[31:24] = len;
    for (int i = 0; i < int'(len); i++) fd[23-8*i -: 8] = q[2+i];
    if (crc_xor != 8'h00) err_q.push_back(3'd1);
    else if (ovr)         err_q.push_back(3'd4);
    else                  data_q.push_back(fd);
    drive_gap(8'hFE);
    foreach (q[i]) drive_gap(q[i]);
    drive_gap(crc[31:24]);
    drive_gap(crc[23:16]);
    drive_gap(crc[15:8]);
    drive_gap(crc[7:0] ^ crc_xor);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents a result.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (data_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_frame: got 0x%0h expected none", full_data);
      end else begin
        check("frame", 64'(full_data), 64'(data_q.pop_front()));
      end
    end
    if (!RST && err_valid) begin
      if (err_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_error: got code %0d expected none", err_code);
      end else begin
        check("err_code", 64'(err_code), 64'(err_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] c;
    logic [FDS-1:0] held;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
      crc_tbl[i] = c;
    end

    RST = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    idle(3);
    check("rst_full_data", 64'(full_data), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_err_valid", 64'(err_valid), 64'h0);
    check("rst_err_code",  64'(err_code),  64'h0);
    RST = 1'b0;
    idle(2);

    // Good frame, then the same frame with a corrupted last CRC byte.
    send_frame(8'h01, 8'h02, 24'hAA5500, 8'h00, 1'b0);
    idle(5);
    send_frame(8'h01, 8'h02, 24'hAA5500, 8'h01, 1'b0);
    idle(5);
    check("crc_err_no_valid", 64'(out_valid), 64'h0);

    // Leading garbage, then a zero-length frame.
    drive(8'h00); drive(8'h13); drive(8'hFF);
    send_frame(8'h07, 8'h00, 24'h0, 8'h00, 1'b0);
    idle(5);

    // Oversized len, then a good frame.
    err_q.push_back(3'd2);
    drive(8'hFE); drive(8'h07); drive(8'h04);
    idle(3);
    send_frame(8'h11, 8'h03, 24'hFE0102, 8'h00, 1'b0);
    idle(5);

    // Inter-byte timeout, then a good frame.
    err_q.push_back(3'd3);
    drive(8'hFE); drive(8'h01);
    cnt = 0;
    while (!err_valid && cnt < 100) begin @(posedge CLK); #1; cnt++; end
    check("timeout_latency_ok", 64'((cnt >= 48 && cnt <= 52) ? 1 : 0), 64'h1);
    idle(10);
    send_frame(8'h22, 8'h01, 24'h5A0000, 8'h00, 1'b0);
    idle(5);

    // Overrun: consumer stalled across two good frames.
    out_ready = 1'b0;
    send_frame(8'h33, 8'h02, 24'h123400, 8'h00, 1'b0);
    held = data_q[data_q.size()-1];
    send_frame(8'h44, 8'h01, 24'h990000, 8'h00, 1'b1);
    idle(4);
    check("overrun_hold_valid", 64'(out_valid), 64'h1);
    check("overrun_hold_data",  64'(full_data), 64'(held));
    out_ready = 1'b1;
    idle(4);

    // Reset mid-frame with a stalled pending output.
    out_ready = 1'b0;
    send_frame(8'h55, 8'h03, 24'h010203, 8'h00, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(posedge CLK); #1; cnt++; end
    check("pre_reset_valid", 64'(out_valid), 64'h1);
    drive(8'hFE); drive(8'h01); drive(8'h03); drive(8'hAA);
    RST = 1'b1;
    void'(data_q.pop_back());
    idle(1);
    check("midrst_full_data", 64'(full_data), 64'h0);
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_err_valid", 64'(err_valid), 64'h0);
    check("midrst_err_code",  64'(err_code),  64'h0);
    RST = 1'b0;
    out_ready = 1'b1;
    idle(2);
    send_frame(8'h66, 8'h02, 24'hBEEF00, 8'h00, 1'b0);
    idle(5);

    // Randomized frames with garbage, gaps and occasional CRC corruption.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] g;
      logic [7:0] x;
      gap_max = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hFE) g = 8'h00;
        drive(g);
      end
      x = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      send_frame(8'($urandom), 8'($urandom_range(0, 3)), 24'($urandom), x, 1'b0);
    end
    gap_max = 0;

    cnt = 0;
    while ((data_q.size() != 0 || err_q.size() != 0) && cnt < 200) begin idle(1); cnt++; end
    idle(3);
    check("data_q_drained", 64'(data_q.size()), 64'h0);
    check("err_q_drained",  64'(err_q.size()),  64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Frame receiver paired with the UART frame transmitter.
- Takes the byte stream from a byte-level UART deserializer and hunts for the start byte 0xFE.
- Captures opt, len, len data bytes and a 4-byte CRC-32, checks the CRC, and presents the frame in the same packed full_data layout the transmitter consumes.
- Detects and reports bad length, CRC mismatch, inter-byte timeout and output overrun.

Parameters:
- FULL_DATA_SIZE, 40, width of packed frame word: opt (top byte), len (next byte), useful data (rest).
- BYTE_SIZE, 8, byte width; only 8 is supported.
- TIMEOUT_CYCLES, 10000, max CLK cycles allowed between consecutive in_valid bytes inside a frame.

Ports:
- CLK, input, 1, clock.
- RST, input, 1, synchronous active-high reset.
- in_byte, input, BYTE_SIZE, received byte from the byte deserializer.
- in_valid, input, 1, one-cycle strobe: in_byte valid. There is no backpressure; every strobe is consumed.
- full_data, output, FULL_DATA_SIZE, {opt, len, data}; data byte 0 occupies bits [FULL_DATA_SIZE-17 -: 8]; unused data bytes are 0.
- out_valid, output, 1, full_data holds a CRC-correct frame.
- out_ready, input, 1, consumer accepts; the handshake is out_valid && out_ready.
- err_valid, output, 1, one-cycle error pulse.
- err_code, output, 3, 1=CRC mismatch, 2=len too large, 3=timeout, 4=overrun; holds the last code.

Behaviour:
- Reset: state=ST_IDLE; full_data=0, out_valid=0, err_valid=0, err_code=0; counters and CRC register cleared.
- Reset mid-frame discards the partial frame with no error pulse.
- MAX_LEN = (FULL_DATA_SIZE-2*BYTE_SIZE)/BYTE_SIZE, which is 3 at the defaults.
- Wire order is 0xFE, opt, len, data[0..len-1], crc[31:24], crc[23:16], crc[15:8], crc[7:0].
- CRC: CRC-32/MPEG-2.
  - poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, no final xor.
  - Bits are processed MSB-first over opt, len and data only.
  - Check value for ASCII "123456789" is 0x0376E6E7.
  - Update is one byte per in_valid; the 8-step combinational unroll is allowed.
- FSM transitions, all taken on in_valid:
  - ST_IDLE: in_byte==0xFE -> ST_OPT; any other byte is ignored silently; CRC reg <= init.
  - ST_OPT: capture opt, CRC update -> ST_LEN.
  - ST_LEN: capture len, CRC update.
    - len > MAX_LEN -> err_code 2, ST_IDLE.
    - len == 0 -> ST_CRC.
    - otherwise -> ST_DATA with byte index 0.
  - ST_DATA: store byte at index, CRC update, index+1; index == len-1 -> ST_CRC.
  - ST_CRC: shift the received byte into the 32-bit rx_crc. After the 4th byte, compare rx_crc with the computed CRC, then go to ST_IDLE.
- Frame clear: the data assembly register is zeroed on entry to ST_OPT, so shorter frames leave zeros in the unused bytes.
- Completion, in the cycle after the 4th CRC byte:
  - CRC match and out_valid==0 (or being accepted that same cycle): load the separate output register and set out_valid.
  - CRC match and out_valid still pending without handshake: drop the new frame, err_code 4, keep the old full_data.
  - CRC mismatch: err_code 1; full_data and out_valid are unchanged.
- out_valid stays high until out_ready is sampled high, then clears next cycle. The output register is independent of assembly, so reception continues meanwhile.
- Timeout: a counter resets on every in_valid and runs in any state other than ST_IDLE. Reaching TIMEOUT_CYCLES -> err_code 3, ST_IDLE.
- A 0xFE byte inside a frame is treated as payload; there is no resync.
- err_valid is high for exactly one cycle per error; err_code updates in that same cycle.

Test Plan:
- Good frame: FE, 01, 02, AA, 55, plus the model CRC of {01,02,AA,55} -> one out_valid, full_data=0x0102AA5500, no err_valid.
- Corrupt the last CRC byte (xor 0x01) of the same frame -> err_valid pulse, err_code=1, out_valid stays 0.
- Leading garbage then a frame:
  - garbage 00, 13, FF, followed by FE, 07, 00, CRC{07,00} -> full_data=0x0700000000, out_valid.
  - len=04 -> err_code=2, FSM back to ST_IDLE, and the next good frame is received.
- Timeout: TIMEOUT_CYCLES=50, send FE, 01, then idle 60 cycles -> err_code=3 near cycle 50 after the last byte; a subsequent good frame is accepted.
- Overrun and reset:
  - hold out_ready=0 while two good frames arrive -> first frame stays on full_data, second gives err_code=4.
  - RST asserted mid-data -> all outputs 0 next cycle, and a fresh frame decodes correctly.
